// File: rtl/sprite_addr_gen_pkg.sv
// Shared types and constants for the sprite address generators.
// Latency: n/a (package only).
// Backpressure: none; the pixel stream is free-running.
package sprite_addr_gen_pkg;

  // Visible screen area and the colour the mapper treats as transparent
  localparam int          SCREEN_W = 640;
  localparam int          SCREEN_H = 480;
  localparam logic [23:0] BG_KEY   = 24'hF442EE;

  // Sprite top-left corner as held in the shadow registers
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } sprite_pos_t;

  // Counter width that stays at least one bit for degenerate sizes
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_addr_gen_if.sv
// Pixel-stream and sprite-control bundle between timing logic and one sprite generator.
// Latency: n/a (wiring only).
// Backpressure: none; every pixel is consumed on the cycle it is presented.
interface sprite_addr_gen_if #(
  parameter int ADDR_W  = 16,
  parameter int FRAME_W = 2
);
  logic               frame_start;
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic [9:0]         pos_x;
  logic [9:0]         pos_y;
  logic               flip_x;
  logic               anim_en;
  logic               visible;
  logic               is_sprite;
  logic [ADDR_W-1:0]  sprite_addr;
  logic [FRAME_W-1:0] anim_frame;

  // Sprite generator side: consumes the pixel stream, produces ROM addressing
  modport master (
    input  frame_start, DrawX, DrawY, pos_x, pos_y, flip_x, anim_en, visible,
    output is_sprite, sprite_addr, anim_frame
  );

  // Timing/control side: drives the pixel stream, consumes ROM addressing
  modport slave (
    output frame_start, DrawX, DrawY, pos_x, pos_y, flip_x, anim_en, visible,
    input  is_sprite, sprite_addr, anim_frame
  );
endinterface

// File: rtl/sprite_addr_gen_anim_counter.sv
// Animation sequencer: holds each frame for FRAME_HOLD ticks, then steps the frame index.
// Latency: anim_frame changes on the clock edge that ends the tick cycle.
// Backpressure: none; ticks are never refused.
module anim_counter
  import sprite_addr_gen_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 8,
  parameter int FRAME_W    = cnt_bits(NUM_FRAMES)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               tick,
  input  logic               clr,
  output logic [FRAME_W-1:0] anim_frame
);
  localparam int HOLD_W = cnt_bits(FRAME_HOLD);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // Next hold count / frame index; clr wins so a paused sprite restarts its hold cleanly
  always_comb begin
    hold_d  = hold_q;
    frame_d = frame_q;
    if (clr) begin
      hold_d = '0;
    end else if (tick) begin
      if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
        hold_d  = '0;
        frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  // Counter state registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end

  assign anim_frame = frame_q;
endmodule

// File: rtl/sprite_addr_gen.sv
// Per-pixel sprite hit test and ROM address generation with vblank-latched position.
// Latency: is_sprite/sprite_addr are registered, one Clk after DrawX/DrawY.
// Backpressure: none; a result is produced every cycle.
module sprite_addr_gen
  import sprite_addr_gen_pkg::*;
#(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 8,
  parameter int ADDR_W     = 16,
  parameter int FRAME_W    = cnt_bits(NUM_FRAMES)
) (
  input  logic              Clk,
  input  logic              Reset,
  sprite_addr_gen_if.master bus
);
  sprite_pos_t       pos_q, pos_d;
  logic              flip_q, flip_d;
  logic              vis_q, vis_d;
  logic              is_q, is_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FRAME_W-1:0] frame;

  logic [10:0] dx11, dy11, px11, py11;
  logic        hit;
  logic [9:0]  col_raw, row_raw, col_eff;

  anim_counter #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FRAME_W    (FRAME_W)
  ) u_anim (
    .Clk        (Clk),
    .Reset      (Reset),
    .tick       (bus.frame_start & bus.anim_en),
    .clr        (bus.frame_start & ~bus.anim_en),
    .anim_frame (frame)
  );

  // Shadow capture only at vblank so a sprite never moves mid-frame
  always_comb begin
    pos_d  = pos_q;
    flip_d = flip_q;
    vis_d  = vis_q;
    if (bus.frame_start) begin
      pos_d  = '{x: bus.pos_x, y: bus.pos_y};
      flip_d = bus.flip_x;
      vis_d  = bus.visible;
    end
  end

  // Hit test in 11 bits so a box hanging off the right/bottom edge clips instead of wrapping
  always_comb begin
    dx11    = {1'b0, bus.DrawX};
    dy11    = {1'b0, bus.DrawY};
    px11    = {1'b0, pos_q.x};
    py11    = {1'b0, pos_q.y};
    hit     = (dx11 >= px11) && (dx11 < px11 + 11'(SPR_W)) &&
              (dy11 >= py11) && (dy11 < py11 + 11'(SPR_H));
    col_raw = bus.DrawX - pos_q.x;
    row_raw = bus.DrawY - pos_q.y;
    col_eff = flip_q ? (10'(SPR_W - 1) - col_raw) : col_raw;
    is_d    = hit && vis_q;
    addr_d  = '0;
    if (is_d) begin
      addr_d = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
             + ADDR_W'(row_raw) * ADDR_W'(SPR_W)
             + ADDR_W'(col_eff);
    end
  end

  // Shadow and output registers; reset forces outputs to zero immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pos_q  <= '0;
      flip_q <= 1'b0;
      vis_q  <= 1'b0;
      is_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      pos_q  <= pos_d;
      flip_q <= flip_d;
      vis_q  <= vis_d;
      is_q   <= is_d;
      addr_q <= addr_d;
    end
  end

  assign bus.is_sprite   = is_q;
  assign bus.sprite_addr = addr_q;
  assign bus.anim_frame  = frame;
endmodule

// File: tb/tb_sprite_addr_gen.sv
// Randomized and directed bench for sprite_addr_gen with a queue-based scoreboard.
// Latency: expects each pixel's result one Clk after it is driven.
// Backpressure: none; one expectation is queued per driven cycle.
module tb_sprite_addr_gen;
  logic Clk = 1'b0;
  logic Reset = 1'b1;

  sprite_addr_gen_if #(.ADDR_W(16), .FRAME_W(2)) bus ();

  sprite_addr_gen dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit is_spr;
    int addr;
    int frame;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;

  // Reference model state: what the sprite "should" look like right now
  int m_x, m_y, m_hold, m_frame;
  bit m_flip, m_vis;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_flip = 0; m_vis = 0; m_hold = 0; m_frame = 0;
  endtask

  // One pixel cycle: drive inputs, predict result from the model, then apply vblank effects
  task automatic cyc(input bit fs, input int dx, input int dy, input int px, input int py,
                     input bit fl, input bit ae, input bit vis);
    exp_t e;
    int col;
    @(posedge Clk);
    #1;
    bus.frame_start = fs;
    bus.DrawX = 10'(dx); bus.DrawY = 10'(dy);
    bus.pos_x = 10'(px); bus.pos_y = 10'(py);
    bus.flip_x = fl; bus.anim_en = ae; bus.visible = vis;
    e.is_spr = m_vis && dx >= m_x && dx < m_x + 64 && dy >= m_y && dy < m_y + 64;
    col = m_flip ? 63 - (dx - m_x) : dx - m_x;
    e.addr = e.is_spr ? (m_frame * 4096 + (dy - m_y) * 64 + col) % 65536 : 0;
    if (fs) begin
      m_x = px; m_y = py; m_flip = fl; m_vis = vis;
      if (ae) begin
        if (m_hold == 7) begin
          m_hold = 0;
          m_frame = (m_frame + 1) % 4;
        end else begin
          m_hold++;
        end
      end else begin
        m_hold = 0;
      end
    end
    e.frame = m_frame;
    exp_q.push_back(e);
  endtask

  // Monitor: every result due at the last edge is compared on the following falling edge
  initial begin
    int n;
    exp_t e;
    forever begin
      @(posedge Clk);
      n = exp_q.size();
      @(negedge Clk);
      if (n > 0 && exp_q.size() > 0 && !Reset) begin
        e = exp_q.pop_front();
        check("is_sprite", int'(bus.is_sprite), int'(e.is_spr));
        check("sprite_addr", int'(bus.sprite_addr), e.addr);
        check("anim_frame", int'(bus.anim_frame), e.frame);
      end
    end
  end

  initial begin
    int px, py;
    bus.frame_start = 0; bus.DrawX = 0; bus.DrawY = 0; bus.pos_x = 0; bus.pos_y = 0;
    bus.flip_x = 0; bus.anim_en = 0; bus.visible = 0;
    model_reset();
    #12;
    check("reset_is_sprite", int'(bus.is_sprite), 0);
    check("reset_addr", int'(bus.sprite_addr), 0);
    check("reset_frame", int'(bus.anim_frame), 0);
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Basic placement, corners and right-edge miss
    cyc(1, 0, 0, 100, 50, 0, 0, 1);
    cyc(0, 100, 50, 100, 50, 0, 0, 1);
    cyc(0, 163, 113, 100, 50, 0, 0, 1);
    cyc(0, 164, 113, 100, 50, 0, 0, 1);
    cyc(0, 99, 50, 100, 50, 0, 0, 1);
    cyc(0, 100, 114, 100, 50, 0, 0, 1);
    // Horizontal mirror
    cyc(1, 0, 0, 100, 50, 1, 0, 1);
    cyc(0, 100, 50, 100, 50, 1, 0, 1);
    cyc(0, 163, 50, 100, 50, 1, 0, 1);
    // Position change without vblank must not move the sprite
    cyc(0, 100, 50, 300, 50, 0, 0, 1);
    cyc(0, 300, 50, 300, 50, 0, 0, 1);
    cyc(1, 0, 0, 300, 50, 0, 0, 1);
    cyc(0, 300, 50, 300, 50, 0, 0, 1);
    cyc(0, 363, 60, 300, 50, 0, 0, 1);
    cyc(0, 100, 50, 300, 50, 0, 0, 1);
    // Animation: 16 vblanks reach frame 2, 16 more wrap back to 0
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 100, 50, 0, 1, 1);
      cyc(0, 100, 50, 100, 50, 0, 1, 1);
    end
    cyc(0, 100, 50, 100, 50, 0, 1, 1);
    for (int i = 0; i < 16; i++) cyc(1, 110, 55, 100, 50, 0, 1, 1);
    cyc(0, 100, 50, 100, 50, 0, 1, 1);
    // Paused animation clears the hold count
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 100, 50, 0, 1, 1);
    cyc(1, 0, 0, 100, 50, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 120, 60, 100, 50, 0, 1, 1);
    // Clipping at the bottom-right of the screen
    cyc(1, 0, 0, 620, 470, 0, 0, 1);
    cyc(0, 639, 479, 620, 470, 0, 0, 1);
    cyc(0, 620, 470, 620, 470, 0, 0, 1);
    // Suppressed sprite
    cyc(1, 0, 0, 100, 50, 0, 0, 0);
    cyc(0, 110, 60, 100, 50, 0, 0, 0);

    // Reset mid-line while the sprite is being drawn
    cyc(1, 0, 0, 100, 50, 0, 0, 1);
    cyc(0, 120, 60, 100, 50, 0, 0, 1);
    @(posedge Clk);
    #1;
    check("pre_reset_hit", int'(bus.is_sprite), 1);
    Reset = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("midreset_is_sprite", int'(bus.is_sprite), 0);
    check("midreset_addr", int'(bus.sprite_addr), 0);
    check("midreset_frame", int'(bus.anim_frame), 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    cyc(0, 10, 10, 100, 50, 0, 0, 1);
    cyc(0, 0, 0, 100, 50, 0, 0, 1);

    // Randomized traffic concentrated around the sprite box
    px = 100; py = 50;
    for (int i = 0; i < 1500; i++) begin
      bit fs;
      int dx, dy;
      fs = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        px = $urandom_range(0, 639);
        py = $urandom_range(0, 479);
      end
      dx = m_x + $urandom_range(0, 79) - 8;
      dy = m_y + $urandom_range(0, 79) - 8;
      if (dx < 0) dx = 0;
      if (dx > 639) dx = 639;
      if (dy < 0) dy = 0;
      if (dy > 479) dy = 479;
      cyc(fs, dx, dy, px, py, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0));
    end
    cyc(0, 0, 0, px, py, 0, 0, 1);
    repeat (3) @(posedge Clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
